// File: rtl/pic_pkg.sv
// Shared definitions for the P8259IC interrupt path: acknowledge FSM states,
// default INTA timing and synchroniser depth.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE1,
        GAP,
        PULSE2,
        HOLD,
        COOLDOWN
    } inta_state_e;

    localparam int PULSE_CYCLES_DEFAULT = 2;
    localparam int GAP_CYCLES_DEFAULT   = 2;
    localparam int COOLDOWN_CYCLES      = 2;
    localparam int SYNC_STAGES          = 2;
    localparam int CNT_W                = 4;

    typedef logic [CNT_W-1:0] dur_cnt_t;

    // A phase lasting n cycles is loaded with n-1 and exits on the cycle the count reads 0.
    function automatic dur_cnt_t dur_load(input int cycles);
        return dur_cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Controller-side INT/INTA/data bus plus CPU-side vector handshake of the
// acknowledge sequencer; master is the sequencer, slave is its environment.
interface inta_sequencer_if;

    logic       interrupt_to_cpu;
    logic       interrupt_enable;
    logic       interrupt_acknowledge_n;
    logic [7:0] data_bus_in;
    logic       data_bus_io;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic       vector_ready;
    logic       vector_error;
    logic       busy;

    modport master (
        input  interrupt_to_cpu,
        input  interrupt_enable,
        input  data_bus_in,
        input  data_bus_io,
        input  vector_ready,
        output interrupt_acknowledge_n,
        output vector_out,
        output vector_valid,
        output vector_error,
        output busy
    );

    modport slave (
        output interrupt_to_cpu,
        output interrupt_enable,
        output data_bus_in,
        output data_bus_io,
        output vector_ready,
        input  interrupt_acknowledge_n,
        input  vector_out,
        input  vector_valid,
        input  vector_error,
        input  busy
    );

endinterface

// File: rtl/int_synchronizer.sv
// Generic multi-flop synchroniser for asynchronous level inputs (INT and IR lines).
module int_synchronizer
    import pic_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    // NOTE: non-blocking assignments make every stage take the pre-edge value of
    // the stage before it; blocking ones would collapse the chain into one flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// 8086-style two-pulse INTA_n sequencer downstream of the P8259IC: synchronises INT,
// runs the pulse pair, captures the vector on the second pulse and hands it to the CPU.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEFAULT,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEFAULT
) (
    input logic              clock,
    input logic              reset,
    inta_sequencer_if.master bus
);

    logic        int_sync;
    logic        cnt_done;
    inta_state_e state_q, state_d;
    dur_cnt_t    cnt_q, cnt_d;
    logic        inta_n_q, inta_n_d;
    logic [7:0]  vector_q, vector_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;

    int_synchronizer #(
        .WIDTH (1),
        .STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(bus.interrupt_to_cpu),
        .sync_out(int_sync)
    );

    assign cnt_done = (cnt_q == '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_done ? cnt_q : cnt_q - dur_cnt_t'(1);
        vector_d = vector_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (int_sync && bus.interrupt_enable) begin
                    state_d = PULSE1;
                    cnt_d   = dur_load(PULSE_CYCLES);
                end
            end
            PULSE1: begin
                if (cnt_done) begin
                    state_d = GAP;
                    cnt_d   = dur_load(GAP_CYCLES);
                end
            end
            GAP: begin
                if (cnt_done) begin
                    state_d = PULSE2;
                    cnt_d   = dur_load(PULSE_CYCLES);
                end
            end
            PULSE2: begin
                // Only the second pulse carries a driven vector; the bus is never sampled in PULSE1.
                if (cnt_done) begin
                    state_d  = HOLD;
                    vector_d = bus.data_bus_in;
                    error_d  = bus.data_bus_io;
                end
            end
            HOLD: begin
                if (bus.vector_ready) begin
                    state_d = COOLDOWN;
                    cnt_d   = dur_load(COOLDOWN_CYCLES);
                end
            end
            COOLDOWN: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop aligned with it.
        inta_n_d = !(state_d == PULSE1 || state_d == PULSE2);
        valid_d  = (state_d == HOLD);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            vector_q <= 8'h00;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.interrupt_acknowledge_n = inta_n_q;
    assign bus.vector_out              = vector_q;
    assign bus.vector_valid            = valid_q;
    assign bus.vector_error            = error_q;
    assign bus.busy                    = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: two instances (2/2 and 1/5 timing) share INT/enable/ready,
// each answered by its own controller model and checked against a timeline reference model.
module tb_inta_sequencer;
    import pic_pkg::*;

    localparam int P_A = 2;
    localparam int G_A = 2;
    localparam int P_B = 1;
    localparam int G_B = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            int_in = 1'b0;
    logic            en = 1'b0;
    logic            ready = 1'b0;
    logic            ctrl_err = 1'b0;
    logic [7:0]      ctrl_vec = 8'h48;
    logic [1:0][7:0] dbus;
    logic [1:0]      dio;

    logic [1:0]      o_inta, o_valid, o_busy, o_err;
    logic [1:0][7:0] o_vec;

    int n_checks = 0;
    int n_pass   = 0;

    inta_sequencer_if if_a ();
    inta_sequencer_if if_b ();

    assign if_a.interrupt_to_cpu = int_in;
    assign if_a.interrupt_enable = en;
    assign if_a.vector_ready     = ready;
    assign if_a.data_bus_in      = dbus[0];
    assign if_a.data_bus_io      = dio[0];
    assign if_b.interrupt_to_cpu = int_in;
    assign if_b.interrupt_enable = en;
    assign if_b.vector_ready     = ready;
    assign if_b.data_bus_in      = dbus[1];
    assign if_b.data_bus_io      = dio[1];

    assign o_inta  = {if_b.interrupt_acknowledge_n, if_a.interrupt_acknowledge_n};
    assign o_valid = {if_b.vector_valid, if_a.vector_valid};
    assign o_busy  = {if_b.busy, if_a.busy};
    assign o_err   = {if_b.vector_error, if_a.vector_error};
    assign o_vec   = {if_b.vector_out, if_a.vector_out};

    inta_sequencer #(.PULSE_CYCLES(P_A), .GAP_CYCLES(G_A)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a));
    inta_sequencer #(.PULSE_CYCLES(P_B), .GAP_CYCLES(G_B)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic int pp(input int i);
        return (i == 0) ? P_A : P_B;
    endfunction

    function automatic int gg(input int i);
        return (i == 0) ? G_A : G_B;
    endfunction

    // Reference model: each acknowledge is a timeline anchored at the edge INTA_n falls.
    int              m_edge = 0;
    logic            s1, s2;
    int              m_start [2];
    int              m_acc   [2];
    int              m_idle_ok [2];
    logic [1:0]      e_inta, e_busy, e_valid;
    logic [8:0]      sb_a [$];
    logic [8:0]      sb_b [$];

    task automatic model_reset();
        s1 = 1'b0;
        s2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_start[i]   = -1;
            m_acc[i]     = -1;
            m_idle_ok[i] = 0;
        end
        e_inta  = 2'b11;
        e_busy  = 2'b00;
        e_valid = 2'b00;
        sb_a.delete();
        sb_b.delete();
    endtask

    task automatic model_step(input int i, input logic trig);
        int p, g, cap, off;
        p = pp(i);
        g = gg(i);
        if (m_start[i] >= 0 && m_acc[i] >= 0 && m_edge >= m_acc[i] + 2) begin
            m_start[i] = -1;
            m_acc[i]   = -1;
        end
        if (m_start[i] < 0) begin
            if (m_edge >= m_idle_ok[i] && trig && en) m_start[i] = m_edge;
        end else begin
            cap = m_start[i] + 2 * p + g;
            if (m_edge == cap) begin
                if (i == 0) sb_a.push_back({dio[0], dbus[0]});
                else        sb_b.push_back({dio[1], dbus[1]});
            end else if (m_edge > cap && m_acc[i] < 0 && ready) begin
                m_acc[i]     = m_edge;
                m_idle_ok[i] = m_edge + 3;
            end
        end
        off        = m_edge - m_start[i];
        e_busy[i]  = (m_start[i] >= 0);
        e_inta[i]  = !(m_start[i] >= 0 && (off < p || (off >= p + g && off < 2 * p + g)));
        e_valid[i] = (m_start[i] >= 0) && (off >= 2 * p + g) && (m_acc[i] < 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                model_reset();
            end else begin
                m_edge++;
                for (int i = 0; i < 2; i++) model_step(i, s2);
                s2 = s1;
                s1 = int_in;
            end
        end
    end

    // Controller model: drives the vector only while the second INTA_n pulse is low.
    int         c_cnt  [2];
    logic [1:0] c_prev;

    initial begin
        c_cnt[0] = 0;
        c_cnt[1] = 0;
        c_prev   = 2'b11;
        dbus     = '0;
        dio      = 2'b11;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    c_cnt[i]  = 0;
                    c_prev[i] = 1'b1;
                    dbus[i]   = 8'($urandom);
                    dio[i]    = 1'b1;
                end else begin
                    if (!o_inta[i] && c_prev[i]) c_cnt[i]++;
                    c_prev[i] = o_inta[i];
                    if (!o_inta[i] && (c_cnt[i] % 2 == 0)) begin
                        dbus[i] = ctrl_vec;
                        dio[i]  = ctrl_err;
                    end else begin
                        dbus[i] = 8'($urandom);
                        dio[i]  = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle pin checks plus scoreboard pop on each new vector.
    logic [1:0] mon_prev_valid = 2'b00;
    logic [8:0] mon_cur [2];

    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("inta_n[%0d]@%0t", i, $time), o_inta[i], e_inta[i]);
                check($sformatf("busy[%0d]@%0t", i, $time), o_busy[i], e_busy[i]);
                check($sformatf("valid[%0d]@%0t", i, $time), o_valid[i], e_valid[i]);
                if (reset) begin
                    mon_prev_valid[i] = 1'b0;
                end else begin
                    if (o_valid[i] && !mon_prev_valid[i]) begin
                        if (i == 0) begin
                            check("sb_pending[0]", sb_a.size() != 0, 1);
                            mon_cur[0] = (sb_a.size() != 0) ? sb_a.pop_front() : 9'h0;
                        end else begin
                            check("sb_pending[1]", sb_b.size() != 0, 1);
                            mon_cur[1] = (sb_b.size() != 0) ? sb_b.pop_front() : 9'h0;
                        end
                    end
                    if (o_valid[i]) begin
                        check($sformatf("vector[%0d]@%0t", i, $time), o_vec[i], mon_cur[i][7:0]);
                        check($sformatf("verror[%0d]@%0t", i, $time), o_err[i], mon_cur[i][8]);
                    end
                    mon_prev_valid[i] = o_valid[i];
                end
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic wait_inta_a_low(input int budget);
        int k;
        k = 0;
        while (if_a.interrupt_acknowledge_n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("inta_a_fell_in_time", if_a.interrupt_acknowledge_n, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cycles(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_vec[%0d]", i), o_vec[i], 8'h00);
            check($sformatf("rst_err[%0d]", i), o_err[i], 1'b0);
        end
        #2 reset = 1'b0;

        // Basic acknowledge with default vector; CPU stalls ready in HOLD.
        @(negedge clock);
        int_in = 1'b1;
        en     = 1'b1;
        cycles(40);
        check("vec48_a", o_vec[0], 8'h48);
        check("vec48_b", o_vec[1], 8'h48);
        check("valid_hold_a", o_valid[0], 1'b1);
        check("valid_hold_b", o_valid[1], 1'b1);
        int_in = 1'b0;
        ready  = 1'b1;
        cycles(20);

        // Enable low blocks acknowledges; raising it starts one clock later.
        ready  = 1'b0;
        en     = 1'b0;
        int_in = 1'b1;
        cycles(20);
        check("blocked_busy_a", o_busy[0], 1'b0);
        check("blocked_inta_b", o_inta[1], 1'b1);
        en    = 1'b1;
        ready = 1'b1;
        cycles(1);
        check("enable_start_a", o_inta[0], 1'b0);
        check("enable_start_b", o_inta[1], 1'b0);
        cycles(25);
        int_in = 1'b0;
        cycles(20);

        // Controller leaves the bus undriven on the second pulse.
        ready    = 1'b0;
        ctrl_err = 1'b1;
        int_in   = 1'b1;
        cycles(20);
        check("err_flag_a", o_err[0], 1'b1);
        check("err_flag_b", o_err[1], 1'b1);
        check("err_valid_a", o_valid[0], 1'b1);
        ctrl_err = 1'b0;
        int_in   = 1'b0;
        ready    = 1'b1;
        cycles(20);

        // Asynchronous reset in the middle of PULSE1.
        ready  = 1'b0;
        int_in = 1'b1;
        wait_inta_a_low(20);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async_inta[%0d]", i), o_inta[i], 1'b1);
            check($sformatf("async_vec[%0d]", i), o_vec[i], 8'h00);
            check($sformatf("async_err[%0d]", i), o_err[i], 1'b0);
            check($sformatf("async_busy[%0d]", i), o_busy[i], 1'b0);
        end
        cycles(2);
        #2 reset = 1'b0;
        cycles(30);
        ready  = 1'b1;
        int_in = 1'b0;
        cycles(20);

        // Short INT blip that disappears before an acknowledge may start.
        en     = 1'b0;
        int_in = 1'b1;
        cycles(1);
        int_in = 1'b0;
        cycles(4);
        en = 1'b1;
        cycles(10);
        check("blip_idle_b", o_busy[1], 1'b0);
        int_in = 1'b1;
        cycles(20);
        int_in = 1'b0;
        cycles(15);

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 15) == 0) int_in = !int_in;
            en       = ($urandom_range(0, 7) != 0);
            ready    = 1'($urandom_range(0, 1));
            ctrl_err = ($urandom_range(0, 7) == 0);
            ctrl_vec = 8'($urandom);
        end
        int_in = 1'b0;
        ready  = 1'b1;
        cycles(30);
        check("sb_drained_a", sb_a.size(), 0);
        check("sb_drained_b", sb_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
